lsu_bus_master: RTL and testbench

LSU_BUS_MASTER -- requirements
Module: lsu_bus_master

---
 rtl/lsu_pkg.sv | 31 +++
 rtl/lsu_lane_align.sv | 55 +++++
 rtl/lsu_bus_master.sv | 147 ++++++++++++++
 tb/tb_lsu_bus_master.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store bus master: data-size encodings,
// FSM state enum, lane geometry and the illegal-operation check.
package lsu_pkg;

    localparam int LANES  = 4;
    localparam int LANE_W = 8;
    localparam int WORD_W = LANES * LANE_W;

    localparam logic [2:0] DMOP_B  = 3'b000;
    localparam logic [2:0] DMOP_H  = 3'b001;
    localparam logic [2:0] DMOP_W  = 3'b010;
    localparam logic [2:0] DMOP_BU = 3'b100;
    localparam logic [2:0] DMOP_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_ACC0 = 2'b01,
        ST_ACC1 = 2'b10,
        ST_RESP = 2'b11
    } lsu_state_e;

    // Unsigned variants only make sense for loads.
    function automatic logic dmop_illegal(input logic [2:0] op, input logic wr);
        case (op)
            DMOP_B, DMOP_H, DMOP_W: return 1'b0;
            DMOP_BU, DMOP_HU:       return wr;
            default:                return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane steering: byte enables and store data for both halves of
// a possibly word-crossing access, plus load byte gather and extension.
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [2:0]        dmop_i,
    input  logic [1:0]        off_i,
    input  logic [WORD_W-1:0] wdata_i,
    input  logic [WORD_W-1:0] lo_word_i,
    input  logic [23:0]       hi_word_i,
    output logic [LANES-1:0]  be_lo_o,
    output logic [LANES-1:0]  be_hi_o,
    output logic [WORD_W-1:0] wdata_lo_o,
    output logic [WORD_W-1:0] wdata_hi_o,
    output logic              cross_o,
    output logic [WORD_W-1:0] load_o
);

    logic [LANES-1:0]    mask_s;
    logic [2*LANES-1:0]  be8_s;
    logic [2*WORD_W-1:0] wd64_s;
    logic [WORD_W-1:0]   raw_s;

    always_comb begin
        case (dmop_i[1:0])
            2'b00:   mask_s = 4'b0001;
            2'b01:   mask_s = 4'b0011;
            default: mask_s = 4'b1111;
        endcase
        be8_s      = {4'b0000, mask_s} << off_i;
        wd64_s     = {32'h0000_0000, wdata_i} << {off_i, 3'b000};
        be_lo_o    = be8_s[3:0];
        be_hi_o    = be8_s[7:4];
        wdata_lo_o = wd64_s[31:0];
        wdata_hi_o = wd64_s[63:32];
        cross_o    = (be8_s[7:4] != 4'b0000);

        // Little-endian gather: low word supplies lanes off..3, high word the rest.
        case (off_i)
            2'b00:   raw_s = lo_word_i;
            2'b01:   raw_s = {hi_word_i[7:0],  lo_word_i[31:8]};
            2'b10:   raw_s = {hi_word_i[15:0], lo_word_i[31:16]};
            default: raw_s = {hi_word_i[23:0], lo_word_i[31:24]};
        endcase

        case (dmop_i)
            DMOP_B:  load_o = {{24{raw_s[7]}},  raw_s[7:0]};
            DMOP_H:  load_o = {{16{raw_s[15]}}, raw_s[15:0]};
            DMOP_BU: load_o = {24'h00_0000, raw_s[7:0]};
            DMOP_HU: load_o = {16'h0000, raw_s[15:0]};
            default: load_o = raw_s;
        endcase
    end

endmodule

// File: rtl/lsu_bus_master.sv
// Load/store unit bus master: accepts one CPU access, splits word-crossing
// accesses into two memory cycles, and returns a one-cycle response.
module lsu_bus_master
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [2:0]        dmop,
    input  logic [ADDR_W-1:0] addr,
    input  logic [WORD_W-1:0] wdata,
    output logic              resp_valid,
    output logic              resp_err,
    output logic [WORD_W-1:0] rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [LANES-1:0]  mem_be,
    output logic [WORD_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [WORD_W-1:0] mem_rdata
);

    lsu_state_e        state_q;
    logic              we_q;
    logic [2:0]        dmop_q;
    logic [1:0]        off_q;
    logic [WORD_W-1:0] wdata_q;
    logic [WORD_W-1:0] lo_q;
    logic              resp_valid_q, resp_err_q, mem_req_q, mem_we_q;
    logic [WORD_W-1:0] rdata_q, mem_wdata_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [LANES-1:0]  mem_be_q;

    logic              idle_s;
    logic [2:0]        dmop_s;
    logic [1:0]        off_s;
    logic [WORD_W-1:0] wdata_s, lo_word_s, wdata_lo_s, wdata_hi_s, load_s;
    logic [LANES-1:0]  be_lo_s, be_hi_s;
    logic              cross_s;

    // In IDLE the aligner sees the incoming request, otherwise the captured one.
    assign idle_s    = (state_q == ST_IDLE);
    assign dmop_s    = idle_s ? dmop : dmop_q;
    assign off_s     = idle_s ? addr[1:0] : off_q;
    assign wdata_s   = idle_s ? wdata : wdata_q;
    assign lo_word_s = (state_q == ST_ACC1) ? lo_q : mem_rdata;

    lsu_lane_align u_align (
        .dmop_i     (dmop_s),
        .off_i      (off_s),
        .wdata_i    (wdata_s),
        .lo_word_i  (lo_word_s),
        .hi_word_i  (mem_rdata[23:0]),
        .be_lo_o    (be_lo_s),
        .be_hi_o    (be_hi_s),
        .wdata_lo_o (wdata_lo_s),
        .wdata_hi_o (wdata_hi_s),
        .cross_o    (cross_s),
        .load_o     (load_s)
    );

    assign req_ready  = idle_s & ~rst;
    assign resp_valid = resp_valid_q;
    assign resp_err   = resp_err_q;
    assign rdata      = rdata_q;
    assign mem_req    = mem_req_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_be     = mem_be_q;
    assign mem_wdata  = mem_wdata_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            we_q         <= 1'b0;
            dmop_q       <= 3'b000;
            off_q        <= 2'b00;
            wdata_q      <= 32'h0000_0000;
            lo_q         <= 32'h0000_0000;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            rdata_q      <= 32'h0000_0000;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_be_q     <= 4'b0000;
            mem_wdata_q  <= 32'h0000_0000;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (req_valid) begin
                        we_q    <= req_write;
                        dmop_q  <= dmop;
                        off_q   <= addr[1:0];
                        wdata_q <= wdata;
                        rdata_q <= 32'h0000_0000;
                        if (dmop_illegal(dmop, req_write)) begin
                            state_q      <= ST_RESP;
                            resp_valid_q <= 1'b1;
                            resp_err_q   <= 1'b1;
                        end else begin
                            state_q     <= ST_ACC0;
                            mem_req_q   <= 1'b1;
                            mem_we_q    <= req_write;
                            mem_addr_q  <= {addr[ADDR_W-1:2], 2'b00};
                            mem_be_q    <= be_lo_s;
                            mem_wdata_q <= wdata_lo_s;
                        end
                    end
                end
                ST_ACC0, ST_ACC1: begin
                    if (mem_ack) begin
                        if (state_q == ST_ACC0 && cross_s) begin
                            state_q     <= ST_ACC1;
                            lo_q        <= mem_rdata;
                            mem_addr_q  <= mem_addr_q + ADDR_W'(3'd4);
                            mem_be_q    <= be_hi_s;
                            mem_wdata_q <= wdata_hi_s;
                        end else begin
                            state_q      <= ST_RESP;
                            resp_valid_q <= 1'b1;
                            rdata_q      <= we_q ? 32'h0000_0000 : load_s;
                            mem_req_q    <= 1'b0;
                            mem_we_q     <= 1'b0;
                            mem_addr_q   <= '0;
                            mem_be_q     <= 4'b0000;
                            mem_wdata_q  <= 32'h0000_0000;
                        end
                    end
                end
                ST_RESP: begin
                    state_q      <= ST_IDLE;
                    resp_valid_q <= 1'b0;
                    resp_err_q   <= 1'b0;
                    rdata_q      <= 32'h0000_0000;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_bus_master.sv
// Directed bench for lsu_bus_master: a vector table of single accesses with a
// small memory responder, plus sequences for reset and stray-ack behaviour.
module tb_lsu_bus_master;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_write;
    logic [2:0]  dmop;
    logic [31:0] addr, wdata;
    logic        resp_valid, resp_err;
    logic [31:0] rdata;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    lsu_bus_master #(.ADDR_W(32)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .dmop(dmop), .addr(addr), .wdata(wdata),
        .resp_valid(resp_valid), .resp_err(resp_err), .rdata(rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    typedef struct {
        logic        wr;
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] wd;
        logic [31:0] rd0;
        logic [31:0] rd1;
        int          delay;
        logic        err;
        logic [31:0] exp_rdata;
        int          n_acc;
        logic [31:0] addr0;
        logic [3:0]  be0;
        logic [31:0] wd0;
        logic [31:0] addr1;
        logic [3:0]  be1;
        logic [31:0] wd1;
    } vec_t;

    vec_t vecs[14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] lane_mask(input logic [3:0] be);
        return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    endfunction

    task automatic run_vec(input int idx, input vec_t v);
        logic [31:0] r_addr[2];
        logic [3:0]  r_be[2];
        logic [31:0] r_wd[2];
        logic        r_we[2];
        int n_acc = 0;
        int wcnt = 0;
        int lat = 0;
        bit got = 1'b0;
        bit new_acc = 1'b1;
        for (int i = 0; i < 2; i++) begin
            r_addr[i] = 32'h0; r_be[i] = 4'h0; r_wd[i] = 32'h0; r_we[i] = 1'b0;
        end
        @(negedge clk);
        chk($sformatf("v%0d_ready_idle", idx), {31'h0, req_ready}, 32'h1);
        req_valid = 1'b1; req_write = v.wr; dmop = v.op; addr = v.a; wdata = v.wd;
        @(posedge clk);
        #1 req_valid = 1'b0;
        for (int cyc = 1; cyc <= 30 && !got; cyc++) begin
            @(negedge clk);
            mem_ack = 1'b0;
            if (resp_valid) begin
                got = 1'b1;
                lat = cyc;
                chk($sformatf("v%0d_err", idx), {31'h0, resp_err}, {31'h0, v.err});
                chk($sformatf("v%0d_rdata", idx), rdata, v.exp_rdata);
                chk($sformatf("v%0d_ready_in_resp", idx), {31'h0, req_ready}, 32'h0);
                chk($sformatf("v%0d_req_in_resp", idx), {31'h0, mem_req}, 32'h0);
            end else if (mem_req) begin
                if (new_acc) begin
                    if (n_acc < 2) begin
                        r_addr[n_acc] = mem_addr; r_be[n_acc] = mem_be;
                        r_wd[n_acc] = mem_wdata; r_we[n_acc] = mem_we;
                    end
                    new_acc = 1'b0;
                    wcnt = 0;
                end else if (n_acc < 2) begin
                    chk($sformatf("v%0d_hold_addr", idx), mem_addr, r_addr[n_acc]);
                    chk($sformatf("v%0d_hold_be", idx), {28'h0, mem_be}, {28'h0, r_be[n_acc]});
                    chk($sformatf("v%0d_hold_wd", idx), mem_wdata, r_wd[n_acc]);
                end
                mem_rdata = (n_acc == 0) ? v.rd0 : v.rd1;
                if (wcnt == v.delay) begin
                    mem_ack = 1'b1;
                    n_acc++;
                    new_acc = 1'b1;
                end
                wcnt++;
            end
        end
        @(negedge clk);
        mem_ack = 1'b0;
        if (!got) chk($sformatf("v%0d_resp_timeout", idx), 32'h0, 32'h1);
        else if (v.err) begin
            chk($sformatf("v%0d_err_latency_le2", idx), {31'h0, (lat >= 1 && lat <= 2)}, 32'h1);
        end else begin
            chk($sformatf("v%0d_latency", idx), lat, v.n_acc * (v.delay + 1) + 1);
        end
        chk($sformatf("v%0d_n_acc", idx), n_acc, v.n_acc);
        if (v.n_acc >= 1) begin
            chk($sformatf("v%0d_addr0", idx), r_addr[0], v.addr0);
            chk($sformatf("v%0d_be0", idx), {28'h0, r_be[0]}, {28'h0, v.be0});
            chk($sformatf("v%0d_we0", idx), {31'h0, r_we[0]}, {31'h0, v.wr});
            if (v.wr) chk($sformatf("v%0d_wd0", idx), r_wd[0] & lane_mask(v.be0), v.wd0);
        end
        if (v.n_acc == 2) begin
            chk($sformatf("v%0d_addr1", idx), r_addr[1], v.addr1);
            chk($sformatf("v%0d_be1", idx), {28'h0, r_be[1]}, {28'h0, v.be1});
            chk($sformatf("v%0d_we1", idx), {31'h0, r_we[1]}, {31'h0, v.wr});
            if (v.wr) chk($sformatf("v%0d_wd1", idx), r_wd[1] & lane_mask(v.be1), v.wd1);
        end
    endtask

    initial begin
        //          wr    op      addr          wdata         rd0           rd1           dly err  rdata         n  addr0         be0      wd0           addr1         be1      wd1
        vecs[0]  = '{1'b0, 3'b000, 32'h0000_0103, 32'h0,        32'h8012_3456, 32'h0,        0, 1'b0, 32'hFFFF_FF80, 1, 32'h0000_0100, 4'b1000, 32'h0,        32'h0,        4'b0000, 32'h0};
        vecs[1]  = '{1'b1, 3'b010, 32'h0000_0102, 32'hA1B2_C3D4, 32'h0,        32'h0,        0, 1'b0, 32'h0,         2, 32'h0000_0100, 4'b1100, 32'hC3D4_0000, 32'h0000_0104, 4'b0011, 32'h0000_A1B2};
        vecs[2]  = '{1'b0, 3'b101, 32'h0000_0003, 32'h0,        32'hAB00_0000, 32'h0000_00CD, 3, 1'b0, 32'h0000_CDAB, 2, 32'h0000_0000, 4'b1000, 32'h0,        32'h0000_0004, 4'b0001, 32'h0};
        vecs[3]  = '{1'b1, 3'b100, 32'h0000_0010, 32'h0000_0055, 32'h0,        32'h0,        0, 1'b1, 32'h0,         0, 32'h0,        4'b0000, 32'h0,        32'h0,        4'b0000, 32'h0};
        vecs[4]  = '{1'b0, 3'b010, 32'h0000_0200, 32'h0,        32'hDEAD_BEEF, 32'h0,        0, 1'b0, 32'hDEAD_BEEF, 1, 32'h0000_0200, 4'b1111, 32'h0,        32'h0,        4'b0000, 32'h0};
        vecs[5]  = '{1'b0, 3'b001, 32'h0000_0102, 32'h0,        32'h8001_7777, 32'h0,        1, 1'b0, 32'hFFFF_8001, 1, 32'h0000_0100, 4'b1100, 32'h0,        32'h0,        4'b0000, 32'h0};
        vecs[6]  = '{1'b0, 3'b100, 32'h0000_0101, 32'h0,        32'h0000_F500, 32'h0,        0, 1'b0, 32'h0000_00F5, 1, 32'h0000_0100, 4'b0010, 32'h0,        32'h0,        4'b0000, 32'h0};
        vecs[7]  = '{1'b1, 3'b001, 32'h0000_0001, 32'h0000_BEEF, 32'h0,        32'h0,        2, 1'b0, 32'h0,         1, 32'h0000_0000, 4'b0110, 32'h00BE_EF00, 32'h0,        4'b0000, 32'h0};
        vecs[8]  = '{1'b0, 3'b011, 32'h0000_0040, 32'h0,        32'h0,        32'h0,        0, 1'b1, 32'h0,         0, 32'h0,        4'b0000, 32'h0,        32'h0,        4'b0000, 32'h0};
        vecs[9]  = '{1'b0, 3'b010, 32'hFFFF_FFFE, 32'h0,        32'h2211_0000, 32'h0000_4433, 0, 1'b0, 32'h4433_2211, 2, 32'hFFFF_FFFC, 4'b1100, 32'h0,        32'h0000_0000, 4'b0011, 32'h0};
        vecs[10] = '{1'b1, 3'b000, 32'h0000_0002, 32'h1234_565A, 32'h0,        32'h0,        0, 1'b0, 32'h0,         1, 32'h0000_0000, 4'b0100, 32'h005A_0000, 32'h0,        4'b0000, 32'h0};
        vecs[11] = '{1'b0, 3'b001, 32'h0000_0007, 32'h0,        32'hFE00_0000, 32'h0000_00FF, 1, 1'b0, 32'hFFFF_FFFE, 2, 32'h0000_0004, 4'b1000, 32'h0,        32'h0000_0008, 4'b0001, 32'h0};
        vecs[12] = '{1'b0, 3'b111, 32'h0000_0000, 32'h0,        32'h0,        32'h0,        0, 1'b1, 32'h0,         0, 32'h0,        4'b0000, 32'h0,        32'h0,        4'b0000, 32'h0};
        vecs[13] = '{1'b1, 3'b101, 32'h0000_0000, 32'h0,        32'h0,        32'h0,        0, 1'b1, 32'h0,         0, 32'h0,        4'b0000, 32'h0,        32'h0,        4'b0000, 32'h0};

        rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; dmop = 3'b000;
        addr = 32'h0; wdata = 32'h0; mem_ack = 1'b0; mem_rdata = 32'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", {31'h0, req_ready}, 32'h0);
        chk("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
        chk("rst_mem_req", {31'h0, mem_req}, 32'h0);
        chk("rst_outs_or", {31'h0, (resp_err | mem_we | (|mem_addr) | (|mem_be) | (|mem_wdata) | (|rdata))}, 32'h0);
        rst = 1'b0;
        #1 chk("ready_after_rst", {31'h0, req_ready}, 32'h1);

        for (int i = 0; i < 14; i++) run_vec(i, vecs[i]);

        // A stray ack with no request outstanding must not start anything.
        @(negedge clk);
        mem_ack = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0;
        chk("stray_ack_ready", {31'h0, req_ready}, 32'h1);
        chk("stray_ack_resp", {31'h0, resp_valid}, 32'h0);
        chk("stray_ack_req", {31'h0, mem_req}, 32'h0);

        // Reset while waiting on the second half of a crossing word load.
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b0; dmop = 3'b010; addr = 32'h0000_0001;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        chk("rst_seq_acc0_req", {31'h0, mem_req}, 32'h1);
        mem_rdata = 32'h1111_1111;
        mem_ack = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0;
        chk("rst_seq_acc1_req", {31'h0, mem_req}, 32'h1);
        chk("rst_seq_acc1_addr", mem_addr, 32'h0000_0004);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("rst_seq_req_drop", {31'h0, mem_req}, 32'h0);
        chk("rst_seq_no_resp", {31'h0, resp_valid}, 32'h0);
        chk("rst_seq_ready_low", {31'h0, req_ready}, 32'h0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1 chk("rst_seq_ready_high", {31'h0, req_ready}, 32'h1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_seq_no_late_resp", {31'h0, resp_valid}, 32'h0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
